// File: rtl/uart_rx.sv
// uart_rx: 16x-oversampled asynchronous serial receiver (8N1 by default).
// A two-flop synchroniser feeds a four-state FSM (IDLE/START/DATA/STOP) that
// advances only on clken ticks. It presents each byte with rdy, framing_err
// and overrun flags.
// Optional feature, macro UART_RX_PARITY_EN: adds a PARITY state after DATA
// (even parity expected) and a parity_err output.
//
// Host handshake: rdy rises when a frame completes and holds until the host
// pulses rdy_clr. If a frame completes on the same edge as rdy_clr, the
// completion wins. overrun records that a frame landed while rdy was still
// set. framing_err and parity_err describe the most recent frame only.
module uart_rx #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk_50m,
  input  logic                 rst_n,
  input  logic                 clken,
  input  logic                 rx,
  input  logic                 rdy_clr,
  output logic [DATA_BITS-1:0] data,
  output logic                 rdy,
  output logic                 framing_err,
  output logic                 overrun,
`ifdef UART_RX_PARITY_EN
  output logic                 parity_err,
`endif
  output logic [2:0]           state_dbg
);

  localparam int SAMPLE_W = $clog2(OVERSAMPLE);
  localparam int BIT_W    = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [SAMPLE_W-1:0] SAMPLE_LAST = SAMPLE_W'(OVERSAMPLE - 1);
  localparam logic [SAMPLE_W-1:0] SAMPLE_MID  = SAMPLE_W'(OVERSAMPLE / 2 - 1);
  localparam logic [BIT_W-1:0]    BIT_LAST    = BIT_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    STOP   = 3'd3
`ifdef UART_RX_PARITY_EN
    ,
    PARITY = 3'd4
`endif
  } state_t;

  state_t                state, state_nxt;
  logic                  rx_m, rx_s;
  logic [SAMPLE_W-1:0]   sample, sample_nxt;
  logic [BIT_W-1:0]      bit_idx, bit_nxt;
  logic [DATA_BITS-1:0]  shift, shift_nxt;
  logic                  done;
`ifdef UART_RX_PARITY_EN
  logic                  par_bit, par_nxt;
`endif

  assign state_dbg = state;

  // Two-flop synchroniser for the asynchronous line; idle level is high.
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  // FSM state and bit-timing counters; all of them hold while clken is low.
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      sample  <= '0;
      bit_idx <= '0;
      shift   <= '0;
`ifdef UART_RX_PARITY_EN
      par_bit <= 1'b0;
`endif
    end else begin
      state   <= state_nxt;
      sample  <= sample_nxt;
      bit_idx <= bit_nxt;
      shift   <= shift_nxt;
`ifdef UART_RX_PARITY_EN
      par_bit <= par_nxt;
`endif
    end
  end

  // Next-state logic: sample in the centre of each bit. Return to IDLE at
  // mid stop bit so that a back-to-back start edge is not missed.
  always_comb begin
    state_nxt  = state;
    sample_nxt = sample;
    bit_nxt    = bit_idx;
    shift_nxt  = shift;
    done       = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_nxt    = par_bit;
`endif
    if (clken) begin
      case (state)
        IDLE: begin
          if (!rx_s) begin
            state_nxt  = START;
            sample_nxt = '0;
          end
        end
        START: begin
          if (rx_s) begin
            state_nxt = IDLE;  // line went high before mid start bit: glitch
          end else if (sample == SAMPLE_MID) begin
            sample_nxt = '0;
            bit_nxt    = '0;
            state_nxt  = DATA;
          end else begin
            sample_nxt = sample + 1'b1;
          end
        end
        DATA: begin
          if (sample == SAMPLE_LAST) begin
            sample_nxt = '0;
            shift_nxt  = {rx_s, shift[DATA_BITS-1:1]};
            if (bit_idx == BIT_LAST) begin
              bit_nxt = '0;
`ifdef UART_RX_PARITY_EN
              state_nxt = PARITY;
`else
              state_nxt = STOP;
`endif
            end else begin
              bit_nxt = bit_idx + 1'b1;
            end
          end else begin
            sample_nxt = sample + 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (sample == SAMPLE_LAST) begin
            sample_nxt = '0;
            par_nxt    = rx_s;
            state_nxt  = STOP;
          end else begin
            sample_nxt = sample + 1'b1;
          end
        end
`endif
        STOP: begin
          if (sample == SAMPLE_LAST) begin
            sample_nxt = '0;
            done       = 1'b1;
            state_nxt  = IDLE;
          end else begin
            sample_nxt = sample + 1'b1;
          end
        end
        default: begin
          state_nxt  = IDLE;
          sample_nxt = '0;
        end
      endcase
    end
  end

  // Host-facing outputs: frame completion takes priority over rdy_clr.
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      data        <= '0;
      rdy         <= 1'b0;
      framing_err <= 1'b0;
      overrun     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err  <= 1'b0;
`endif
    end else if (done) begin
      data        <= shift;
      rdy         <= 1'b1;
      framing_err <= ~rx_s;
      overrun     <= rdy;
`ifdef UART_RX_PARITY_EN
      parity_err  <= (^shift) ^ par_bit;
`endif
    end else if (rdy_clr) begin
      rdy     <= 1'b0;
      overrun <= 1'b0;
    end
  end

endmodule
